// File: rtl/csa_accum_seq.sv
// rtl/csa_accum_seq.sv - sequential carry-save accumulator with a single final carry-propagate add
// Operands stream in one per beat and are folded into a (sum, carry) pair; the pair is resolved on the last beat.
module csa_accum_seq #(
    parameter int MAX = 7,
    parameter int CW  = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear,
    input  logic [MAX-1:0] in_data,
    input  logic           in_valid,
    input  logic           in_last,
    output logic           in_ready,
    output logic [MAX-1:0] out_data,
    output logic [CW-1:0]  out_cnt,
    output logic           out_valid,
    input  logic           out_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        SUM  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         state_q;
    logic [MAX-1:0] acc_s_q;
    logic [MAX-1:0] acc_c_q;
    logic [MAX-1:0] result_q;
    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  out_cnt_q;
    logic           out_valid_q;

    logic [MAX-1:0] maj;
    logic [MAX-1:0] csa_s_d;
    logic [MAX-1:0] csa_c_d;
    logic [CW-1:0]  cnt_inc_d;

    // 3:2 compression; the carry out of the MSB falls off because everything is mod 2^MAX.
    assign maj       = (acc_s_q & acc_c_q) | (acc_s_q & in_data) | (acc_c_q & in_data);
    assign csa_s_d   = acc_s_q ^ acc_c_q ^ in_data;
    assign csa_c_d   = {maj[MAX-2:0], 1'b0};
    assign cnt_inc_d = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);

    assign in_ready  = (state_q == IDLE) || (state_q == ACC);
    assign out_data  = result_q;
    assign out_cnt   = out_cnt_q;
    assign out_valid = out_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_s_q     <= '0;
            acc_c_q     <= '0;
            result_q    <= '0;
            cnt_q       <= '0;
            out_cnt_q   <= '0;
            out_valid_q <= 1'b0;
        end else if (clear) begin
            state_q     <= IDLE;
            acc_s_q     <= '0;
            acc_c_q     <= '0;
            result_q    <= '0;
            cnt_q       <= '0;
            out_cnt_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        acc_s_q <= in_data;
                        acc_c_q <= '0;
                        cnt_q   <= CW'(1);
                        state_q <= in_last ? SUM : ACC;
                    end
                end
                ACC: begin
                    if (in_valid) begin
                        acc_s_q <= csa_s_d;
                        acc_c_q <= csa_c_d;
                        cnt_q   <= cnt_inc_d;
                        if (in_last) begin
                            state_q <= SUM;
                        end
                    end
                end
                SUM: begin
                    result_q    <= acc_s_q + acc_c_q;
                    out_cnt_q   <= cnt_q;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    // Result registers are left alone so out_data stays readable after handoff.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        acc_s_q     <= '0;
                        acc_c_q     <= '0;
                        cnt_q       <= '0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_accum_seq.sv
// tb/tb_csa_accum_seq.sv - scoreboard bench for csa_accum_seq (MAX=8, CW=4)
module tb_csa_accum_seq;

    localparam int MAX = 8;
    localparam int CW  = 4;

    typedef struct packed {
        logic [MAX-1:0] data;
        logic [CW-1:0]  cnt;
    } exp_t;

    logic           clk;
    logic           rst_n;
    logic           clear;
    logic [MAX-1:0] in_data;
    logic           in_valid;
    logic           in_last;
    logic           in_ready;
    logic [MAX-1:0] out_data;
    logic [CW-1:0]  out_cnt;
    logic           out_valid;
    logic           out_ready;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];
    int   pkt[64];
    int   pkt_n;

    csa_accum_seq #(.MAX(MAX), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_cnt   (out_cnt),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_output", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_data", 32'(out_data), 32'(e.data));
                check("out_cnt", 32'(out_cnt), 32'(e.cnt));
            end
        end
    end

    task automatic send_beat(input logic [MAX-1:0] d, input logic last);
        int w;
        w = 0;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_packet(input bit push, input bit gaps);
        logic [MAX-1:0] sum;
        exp_t e;
        sum = '0;
        for (int i = 0; i < pkt_n; i++) sum = sum + MAX'(pkt[i]);
        e.data = sum;
        e.cnt  = (pkt_n > 15) ? CW'(15) : CW'(pkt_n);
        if (push) sb.push_back(e);
        for (int i = 0; i < pkt_n; i++) begin
            send_beat(MAX'(pkt[i]), i == pkt_n - 1);
            if (gaps && i != pkt_n - 1) begin
                repeat (i + 1) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_cnt", 32'(out_cnt), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Basic 3+5+7 with latency check
        pkt_n = 3; pkt[0] = 3; pkt[1] = 5; pkt[2] = 7;
        run_packet(1'b1, 1'b0);
        check("basic_lat_t1_valid", 32'(out_valid), 32'd0);
        check("basic_lat_t1_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("basic_lat_t2_valid", 32'(out_valid), 32'd1);
        wait_drain();
        check("basic_idle_ready", 32'(in_ready), 32'd1);

        // Wrap-around
        pkt_n = 3; pkt[0] = 200; pkt[1] = 100; pkt[2] = 255;
        run_packet(1'b1, 1'b0);
        wait_drain();

        // Single operand
        pkt_n = 1; pkt[0] = 'h5A;
        run_packet(1'b1, 1'b0);
        check("single_sum_ready", 32'(in_ready), 32'd0);
        wait_drain();

        // Gaps inside packet and consumer backpressure
        out_ready = 1'b0;
        pkt_n = 4; pkt[0] = 1; pkt[1] = 2; pkt[2] = 3; pkt[3] = 4;
        run_packet(1'b1, 1'b1);
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        check("bp_valid_seen", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_data", 32'(out_data), 32'd10);
            check("bp_hold_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_handoff_valid", 32'(out_valid), 32'd0);
        check("sb_after_bp", 32'(sb.size()), 32'd0);

        // Saturating count
        pkt_n = 20;
        for (int i = 0; i < 20; i++) pkt[i] = 1;
        run_packet(1'b1, 1'b0);
        wait_drain();

        // Clear on the accept of the 2nd operand drops the packet
        send_beat(8'd50, 1'b0);
        in_data  = 8'd60;
        in_valid = 1'b1;
        in_last  = 1'b1;
        clear    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        clear    = 1'b0;
        check("clear_ready", 32'(in_ready), 32'd1);
        repeat (4) begin
            @(negedge clk);
            check("clear_no_output", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        pkt_n = 2; pkt[0] = 9; pkt[1] = 9;
        run_packet(1'b1, 1'b0);
        wait_drain();

        // Async reset while holding a result in DONE
        out_ready = 1'b0;
        pkt_n = 2; pkt[0] = 4; pkt[1] = 6;
        run_packet(1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_done_valid_before", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", 32'(out_valid), 32'd0);
        check("rst_async_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("rst_release_ready", 32'(in_ready), 32'd1);
        check("rst_release_valid", 32'(out_valid), 32'd0);
        check("sb_final", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
